// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared encodings, field positions and decoded-output type for decode
package decode_pkg;

  typedef enum logic [1:0] {
    OP_DP  = 2'b00,
    OP_MEM = 2'b01,
    OP_BR  = 2'b10,
    OP_UND = 2'b11
  } op_e;

  typedef enum logic [3:0] {
    CMD_AND = 4'h0,
    CMD_EOR = 4'h1,
    CMD_SUB = 4'h2,
    CMD_RSB = 4'h3,
    CMD_ADD = 4'h4,
    CMD_ADC = 4'h5,
    CMD_SBC = 4'h6,
    CMD_RSC = 4'h7,
    CMD_TST = 4'h8,
    CMD_TEQ = 4'h9,
    CMD_CMP = 4'hA,
    CMD_CMN = 4'hB,
    CMD_ORR = 4'hC,
    CMD_MOV = 4'hD,
    CMD_BIC = 4'hE,
    CMD_MVN = 4'hF
  } dp_cmd_e;

  localparam int OP_HI     = 27;
  localparam int OP_LO     = 26;
  localparam int CMD_HI    = 24;
  localparam int CMD_LO    = 21;
  localparam int RN_HI     = 19;
  localparam int RN_LO     = 16;
  localparam int RD_HI     = 15;
  localparam int RD_LO     = 12;
  localparam int RM_HI     = 3;
  localparam int RM_LO     = 0;
  localparam int IMM12_HI  = 11;
  localparam int BR_IMM_HI = 23;
  localparam int P_BIT     = 24;
  localparam int U_BIT     = 23;
  localparam int B_BIT     = 22;
  localparam int L_BIT     = 20;
  localparam int BL_BIT    = 24;

  localparam logic [3:0] LR_IDX = 4'd14;

  typedef struct packed {
    logic [3:0]  rd;
    logic [3:0]  rn;
    logic [3:0]  rm;
    logic [3:0]  funct;
    logic [23:0] imm;
    logic        mem;
    logic        reg_wr;
  } dec_t;

  // Compare-class commands (TST/TEQ/CMP/CMN) only update flags.
  function automatic logic dp_writes_reg(input logic [3:0] cmd);
    return !((cmd >= CMD_TST) && (cmd <= CMD_CMN));
  endfunction

endpackage

// File: rtl/decode_if.sv
// rtl/decode_if.sv - instruction word in, decoded fields out
interface decode_if;
  logic [31:0] instruction;
  logic [3:0]  rd;
  logic [3:0]  rn;
  logic [3:0]  rm;
  logic [3:0]  funct;
  logic [23:0] imm;
  logic        MEM;
  logic        REG_WR;

  modport master (
    output instruction,
    input  rd, rn, rm, funct, imm, MEM, REG_WR
  );

  modport slave (
    input  instruction,
    output rd, rn, rm, funct, imm, MEM, REG_WR
  );
endinterface

// File: rtl/decode_fields.sv
// rtl/decode_fields.sv - combinational split of an instruction word into decoded fields
module decode_fields
  import decode_pkg::*;
(
  input  logic [31:0] instruction,
  output dec_t        dec
);

  op_e        op;
  logic [3:0] cmd;
  logic       unused_bits;

  assign op  = op_e'(instruction[OP_HI:OP_LO]);
  assign cmd = instruction[CMD_HI:CMD_LO];

  // Condition field and I bit are resolved downstream.
  assign unused_bits = ^{instruction[31:28], instruction[25]};

  always_comb begin
    dec = '0;
    case (op)
      OP_DP: begin
        dec.funct  = cmd;
        dec.rn     = instruction[RN_HI:RN_LO];
        dec.rd     = instruction[RD_HI:RD_LO];
        dec.rm     = instruction[RM_HI:RM_LO];
        dec.imm    = {12'b0, instruction[IMM12_HI:0]};
        dec.reg_wr = dp_writes_reg(cmd);
      end
      OP_MEM: begin
        dec.funct  = {instruction[P_BIT], instruction[U_BIT],
                      instruction[B_BIT], instruction[L_BIT]};
        dec.rn     = instruction[RN_HI:RN_LO];
        dec.rd     = instruction[RD_HI:RD_LO];
        dec.rm     = instruction[RM_HI:RM_LO];
        dec.imm    = {12'b0, instruction[IMM12_HI:0]};
        dec.mem    = 1'b1;
        dec.reg_wr = instruction[L_BIT];
      end
      OP_BR: begin
        dec.funct = {instruction[BL_BIT], 3'b000};
        dec.imm   = instruction[BR_IMM_HI:0];
        if (instruction[BL_BIT]) begin
          dec.rd     = LR_IDX;
          dec.reg_wr = 1'b1;
        end
      end
      default: dec = '0;
    endcase
  end

endmodule

// File: rtl/decode.sv
// rtl/decode.sv - registered ARM-subset instruction decoder, one-cycle latency
module decode
  import decode_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  decode_if.slave bus
);

  dec_t next_dec;
  dec_t dec_q;

  decode_fields u_fields (
    .instruction (bus.instruction),
    .dec         (next_dec)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      dec_q <= '0;
    end else begin
      dec_q <= next_dec;
    end
  end

  assign bus.rd     = dec_q.rd;
  assign bus.rn     = dec_q.rn;
  assign bus.rm     = dec_q.rm;
  assign bus.funct  = dec_q.funct;
  assign bus.imm    = dec_q.imm;
  assign bus.MEM    = dec_q.mem;
  assign bus.REG_WR = dec_q.reg_wr;

endmodule

// File: tb/tb_decode.sv
// tb/tb_decode.sv - table-driven check of decode with reset sequences
module tb_decode;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  decode_if dif ();

  decode dut (
    .clk (clk),
    .rst (rst),
    .bus (dif.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [3:0]  rd;
    logic [3:0]  rn;
    logic [3:0]  rm;
    logic [3:0]  funct;
    logic [23:0] imm;
    logic        mem;
    logic        reg_wr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic [31:0] instr, logic [3:0] rd, logic [3:0] rn,
                              logic [3:0] rm, logic [3:0] funct, logic [23:0] imm,
                              logic mem, logic reg_wr);
    vec_t v;
    v.name = name; v.instr = instr; v.rd = rd; v.rn = rn; v.rm = rm;
    v.funct = funct; v.imm = imm; v.mem = mem; v.reg_wr = reg_wr;
    return v;
  endfunction

  function automatic logic [41:0] pack_exp(vec_t v);
    return {v.rd, v.rn, v.rm, v.funct, v.imm, v.mem, v.reg_wr};
  endfunction

  function automatic logic [41:0] pack_act();
    return {dif.rd, dif.rn, dif.rm, dif.funct, dif.imm, dif.MEM, dif.REG_WR};
  endfunction

  task automatic check(string name, logic [41:0] act, logic [41:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got rd/rn/rm/funct/imm/mem/regwr=%h/%h/%h/%h/%h/%b/%b want %h/%h/%h/%h/%h/%b/%b",
               name, act[41:38], act[37:34], act[33:30], act[29:26], act[25:2], act[1], act[0],
               exp[41:38], exp[37:34], exp[33:30], exp[29:26], exp[25:2], exp[1], exp[0]);
    end
  endtask

  task automatic apply(logic [31:0] instr, logic r);
    @(negedge clk);
    dif.instruction = instr;
    rst = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            name       instr         rd    rn    rm    fn    imm         mem   wr
    vecs.push_back(mk("mov",   32'he3a00000, 4'h0, 4'h0, 4'h0, 4'hD, 24'h000000, 1'b0, 1'b1));
    vecs.push_back(mk("ldr",   32'he5901000, 4'h1, 4'h0, 4'h0, 4'hD, 24'h000000, 1'b1, 1'b1));
    vecs.push_back(mk("str",   32'he5804000, 4'h4, 4'h0, 4'h0, 4'hC, 24'h000000, 1'b1, 1'b0));
    vecs.push_back(mk("cmp",   32'he35100ff, 4'h0, 4'h1, 4'hF, 4'hA, 24'h0000FF, 1'b0, 1'b0));
    vecs.push_back(mk("add",   32'he2800004, 4'h0, 4'h0, 4'h4, 4'h4, 24'h000004, 1'b0, 1'b1));
    vecs.push_back(mk("beq",   32'h0a00003f, 4'h0, 4'h0, 4'h0, 4'h0, 24'h00003F, 1'b0, 1'b0));
    vecs.push_back(mk("b",     32'heaffffdf, 4'h0, 4'h0, 4'h0, 4'h0, 24'hFFFFDF, 1'b0, 1'b0));
    vecs.push_back(mk("bl",    32'heb000010, 4'hE, 4'h0, 4'h0, 4'h8, 24'h000010, 1'b0, 1'b1));
    vecs.push_back(mk("tst",   32'he1110002, 4'h0, 4'h1, 4'h2, 4'h8, 24'h000002, 1'b0, 1'b0));
    vecs.push_back(mk("cmn",   32'he1720003, 4'h0, 4'h2, 4'h3, 4'hB, 24'h000003, 1'b0, 1'b0));
    vecs.push_back(mk("orr",   32'he1811002, 4'h1, 4'h1, 4'h2, 4'hC, 24'h000002, 1'b0, 1'b1));
    vecs.push_back(mk("mvn",   32'he1e03004, 4'h3, 4'h0, 4'h4, 4'hF, 24'h000004, 1'b0, 1'b1));
    vecs.push_back(mk("ldrbw", 32'he5f12008, 4'h2, 4'h1, 4'h8, 4'hF, 24'h000008, 1'b1, 1'b1));
    vecs.push_back(mk("movc0", 32'h03a00000, 4'h0, 4'h0, 4'h0, 4'hD, 24'h000000, 1'b0, 1'b1));
    vecs.push_back(mk("undef", 32'hec123456, 4'h0, 4'h0, 4'h0, 4'h0, 24'h000000, 1'b0, 1'b0));

    dif.instruction = 32'he3a00000;
    rst = 1'b0;

    // Reset discards the instruction sampled at the same edge.
    apply(32'heb000010, 1'b0);
    check("reset", pack_act(), 42'h0);

    foreach (vecs[i]) begin
      apply(vecs[i].instr, 1'b1);
      check(vecs[i].name, pack_act(), pack_exp(vecs[i]));
    end

    // Output holds until the next edge even after the input changes.
    apply(32'heb000010, 1'b1);
    @(negedge clk);
    dif.instruction = 32'he5804000;
    #2;
    check("hold_bl", pack_act(), pack_exp(vecs[7]));

    // Reset mid-stream, then the first edge with rst high decodes again.
    apply(32'he5901000, 1'b0);
    check("mid_reset", pack_act(), 42'h0);
    apply(32'he5901000, 1'b1);
    check("post_reset_ldr", pack_act(), pack_exp(vecs[1]));
    apply(32'he35100ff, 1'b1);
    check("post_reset_cmp", pack_act(), pack_exp(vecs[3]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
